input_scheduler: RTL

Sits between button_processing and the game engine. It latches the single-cycle button pulses and the gravity tick as pending requests, and arbitrates them by fixed priority into one command stream with a valid/ready handshake. It owns pause state, once-per-piece hold gating, hard-drop lockout and stale-input discard, so the engine sees at most one legal command per accepted transfer.

---
 rtl/input_sched_pkg.sv | 43 ++++
 rtl/input_scheduler_arbiter.sv | 46 ++++
 rtl/input_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/input_sched_pkg.sv
// Shared types and constants for the input scheduler: command codes, FSM states,
// pending-bit indices and a small popcount helper.
package input_sched_pkg;

  typedef enum logic [2:0] {
    CMD_LEFT    = 3'd0,
    CMD_RIGHT   = 3'd1,
    CMD_ROTATE  = 3'd2,
    CMD_SOFT    = 3'd3,
    CMD_HARD    = 3'd4,
    CMD_HOLD    = 3'd5,
    CMD_GRAVITY = 3'd6
  } cmd_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PAUSED  = 2'd1,
    LOCKOUT = 2'd2
  } sched_state_t;

  localparam int unsigned NUM_SRC = 7;
  localparam int unsigned P_LEFT  = 0;
  localparam int unsigned P_RIGHT = 1;
  localparam int unsigned P_ROT   = 2;
  localparam int unsigned P_SOFT  = 3;
  localparam int unsigned P_HARD  = 4;
  localparam int unsigned P_HOLD  = 5;
  localparam int unsigned P_GRAV  = 6;

  // GRAV is the only non-player source.
  localparam logic [NUM_SRC-1:0] PLAYER_MASK = 7'b011_1111;
  localparam logic [NUM_SRC-1:0] HARD_MASK   = 7'b001_0000;

  function automatic logic [3:0] popcount7(input logic [NUM_SRC-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/input_scheduler_arbiter.sv
// Combinational fixed-priority arbiter: HARD > HOLD > ROT > L/R > SOFT > GRAV.
// Simultaneous L and R cancel each other and are never granted.
module cmd_priority_arbiter
  import input_sched_pkg::*;
(
  input  logic [NUM_SRC-1:0] pending_in,
  input  logic               hold_used_in,
  output logic [NUM_SRC-1:0] grant_out,
  output logic               grant_valid_out,
  output cmd_t               cmd_out,
  output logic               cancel_lr_out
);

  always_comb begin
    grant_out       = '0;
    grant_valid_out = 1'b0;
    cmd_out         = CMD_LEFT;
    cancel_lr_out   = pending_in[P_LEFT] & pending_in[P_RIGHT];
    if (pending_in[P_HARD]) begin
      grant_out[P_HARD] = 1'b1;
      cmd_out           = CMD_HARD;
    end else if (pending_in[P_HOLD] && !hold_used_in) begin
      grant_out[P_HOLD] = 1'b1;
      cmd_out           = CMD_HOLD;
    end else if (pending_in[P_ROT]) begin
      grant_out[P_ROT] = 1'b1;
      cmd_out          = CMD_ROTATE;
    end else if (pending_in[P_LEFT] && !pending_in[P_RIGHT]) begin
      grant_out[P_LEFT] = 1'b1;
      cmd_out           = CMD_LEFT;
    end else if (pending_in[P_RIGHT] && !pending_in[P_LEFT]) begin
      grant_out[P_RIGHT] = 1'b1;
      cmd_out            = CMD_RIGHT;
    end else if (pending_in[P_SOFT]) begin
      grant_out[P_SOFT] = 1'b1;
      cmd_out           = CMD_SOFT;
    end else if (pending_in[P_GRAV]) begin
      grant_out[P_GRAV] = 1'b1;
      cmd_out           = CMD_GRAVITY;
    end else begin
      grant_out = '0;
    end
    grant_valid_out = |grant_out;
  end

endmodule

// File: rtl/input_scheduler.sv
// Latches button/gravity pulses, arbitrates them into a valid/ready command stream
// and owns pause, hold gating, hard-drop lockout and stale-input flush.
// Optional macro INPUT_SCHED_STATS_EN adds drop_count_out.
module input_scheduler
  import input_sched_pkg::*;
#(
  parameter int unsigned        AGE_W              = 24,
  parameter logic [AGE_W-1:0]   MAX_PENDING_CYCLES = 24'd6_500_000
) (
  input  logic       clk_in,
  input  logic       reset_n_in,
  input  logic       left_b,
  input  logic       right_b,
  input  logic       rotate_b,
  input  logic       soft_drop_b,
  input  logic       hard_drop_b,
  input  logic       hold_b,
  input  logic       pause_b,
  input  logic       gravity_tick_in,
  input  logic       piece_locked_in,
  input  logic       cmd_ready_in,
  output logic       cmd_valid_out,
  output logic [2:0] cmd_out,
  output logic       paused_out
`ifdef INPUT_SCHED_STATS_EN
  ,
  output logic [7:0] drop_count_out
`endif
);

  sched_state_t       state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [AGE_W-1:0]   age_q, age_d;
  logic               hold_used_q, hold_used_d;
  logic               valid_q, valid_d;
  cmd_t               cmd_q, cmd_d;
  logic               paused_q, paused_d;

  logic [NUM_SRC-1:0] pulse_s, accept_s, arb_grant_s;
  logic               arb_valid_s, arb_cancel_s;
  cmd_t               arb_cmd_s;
  logic               can_load_s, load_s, lock_s, flush_s, hold_blocked_s, player_pending_s;

  cmd_priority_arbiter u_arb (
    .pending_in      (pending_q),
    .hold_used_in    (hold_used_q),
    .grant_out       (arb_grant_s),
    .grant_valid_out (arb_valid_s),
    .cmd_out         (arb_cmd_s),
    .cancel_lr_out   (arb_cancel_s)
  );

  always_comb begin
    pulse_s = {gravity_tick_in, hold_b, hard_drop_b, soft_drop_b, rotate_b, right_b, left_b};
    can_load_s = !valid_q || cmd_ready_in;
    // A pause request suppresses the load in the same cycle: its bits are wiped anyway.
    load_s = can_load_s && arb_valid_s && (state_q != PAUSED) && !pause_b;
    lock_s = (state_q == LOCKOUT) || (load_s && arb_grant_s[P_HARD]);
    player_pending_s = |(pending_q & PLAYER_MASK);
    flush_s = (MAX_PENDING_CYCLES != {AGE_W{1'b0}}) && (age_q == MAX_PENDING_CYCLES)
              && player_pending_s && !load_s;

    hold_used_d = piece_locked_in ? 1'b0 : (hold_used_q | (load_s & arb_grant_s[P_HOLD]));

    accept_s       = lock_s ? (pulse_s & HARD_MASK) : pulse_s;
    hold_blocked_s = accept_s[P_HOLD] && hold_used_d;
    if (hold_blocked_s) begin
      accept_s[P_HOLD] = 1'b0;
    end else begin
      accept_s[P_HOLD] = accept_s[P_HOLD];
    end

    pending_d = pending_q;
    if (load_s) begin
      pending_d = pending_d & ~arb_grant_s;
    end else begin
      pending_d = pending_d;
    end
    if (arb_cancel_s) begin
      pending_d[P_LEFT]  = 1'b0;
      pending_d[P_RIGHT] = 1'b0;
    end else begin
      pending_d = pending_d;
    end
    if (flush_s) begin
      pending_d = pending_d & ~PLAYER_MASK;
    end else begin
      pending_d = pending_d;
    end
    pending_d = pending_d | accept_s;
    if (lock_s) begin
      pending_d = pending_d & HARD_MASK;
    end else begin
      pending_d = pending_d;
    end
    if ((state_q == PAUSED) || pause_b) begin
      pending_d = '0;
    end else begin
      pending_d = pending_d;
    end

    if ((|(pulse_s & PLAYER_MASK)) || load_s || flush_s || !player_pending_s) begin
      age_d = '0;
    end else if (age_q != MAX_PENDING_CYCLES) begin
      age_d = age_q + {{(AGE_W-1){1'b0}}, 1'b1};
    end else begin
      age_d = age_q;
    end

    if (can_load_s) begin
      valid_d = load_s;
      cmd_d   = load_s ? arb_cmd_s : cmd_q;
    end else begin
      valid_d = valid_q;
      cmd_d   = cmd_q;
    end

    state_d = state_q;
    case (state_q)
      RUN: begin
        if (pause_b)                            state_d = PAUSED;
        else if (load_s && arb_grant_s[P_HARD]) state_d = LOCKOUT;
        else                                    state_d = RUN;
      end
      LOCKOUT: begin
        if (pause_b)                            state_d = PAUSED;
        else if (load_s && arb_grant_s[P_HARD]) state_d = LOCKOUT;
        else if (piece_locked_in)               state_d = RUN;
        else                                    state_d = LOCKOUT;
      end
      PAUSED: begin
        if (pause_b) state_d = RUN;
        else         state_d = PAUSED;
      end
      default: state_d = RUN;
    endcase
    paused_d = (state_d == PAUSED);
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q     <= RUN;
      pending_q   <= '0;
      age_q       <= '0;
      hold_used_q <= 1'b0;
      valid_q     <= 1'b0;
      cmd_q       <= CMD_LEFT;
      paused_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      age_q       <= age_d;
      hold_used_q <= hold_used_d;
      valid_q     <= valid_d;
      cmd_q       <= cmd_d;
      paused_q    <= paused_d;
    end
  end

  assign cmd_valid_out = valid_q;
  assign cmd_out       = cmd_q;
  assign paused_out    = paused_q;

`ifdef INPUT_SCHED_STATS_EN
  logic [7:0] drop_q, drop_d;
  logic [3:0] drop_inc_s;
  logic [8:0] drop_sum_s;

  always_comb begin
    drop_inc_s = popcount7(lock_s ? (pulse_s & ~HARD_MASK) : 7'b000_0000)
               + {3'd0, arb_cancel_s} + {3'd0, hold_blocked_s} + {3'd0, flush_s};
    drop_sum_s = {1'b0, drop_q} + {5'd0, drop_inc_s};
    drop_d     = drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) drop_q <= 8'd0;
    else             drop_q <= drop_d;
  end

  assign drop_count_out = drop_q;
`endif

endmodule
